// File: rtl/demux1to6_reg_if.sv
// -----------------------------------------------------------------------------
// demux1to6_reg_if
// Bundles the producer handshake, the six-way consumer handshake and the
// drop/error status of the demux1to6_reg block.
//   master : the environment side (drives D/Sel/in_valid and out_ready)
//   slave  : the demux side (drives in_ready, Y, out_valid, drop_cnt, sel_err)
// Parameters:
//   N     : data word width
//   CNT_W : width of the saturating dropped-word counter
// -----------------------------------------------------------------------------
interface demux1to6_reg_if #(
  parameter int N     = 32,
  parameter int CNT_W = 8
);
  logic [N-1:0]     D;
  logic [2:0]       Sel;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     Y;
  logic [5:0]       out_valid;
  logic [5:0]       out_ready;
  logic [CNT_W-1:0] drop_cnt;
  logic             sel_err;

  modport master (
    output D, Sel, in_valid, out_ready,
    input  in_ready, Y, out_valid, drop_cnt, sel_err
  );

  modport slave (
    input  D, Sel, in_valid, out_ready,
    output in_ready, Y, out_valid, drop_cnt, sel_err
  );
endinterface

// File: rtl/demux1to6_reg.sv
// -----------------------------------------------------------------------------
// demux1to6_reg
// Registered 1-to-6 demultiplexer with valid/ready handshake. One producer word
// is captured into a single holding register and presented on Y with a one-hot
// out_valid selecting the destination port. Words whose select is 110/111 are
// consumed and dropped; they bump a saturating counter and set a sticky error.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : demux1to6_reg_if.slave
//         D, Sel, in_valid -> producer word, destination, valid
//         in_ready         <- block can take a word this cycle
//         Y, out_valid     <- held word, one-hot destination valid
//         out_ready        -> per-port consume strobe
//         drop_cnt, sel_err<- dropped-word count, sticky invalid-select flag
// -----------------------------------------------------------------------------
module demux1to6_reg #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  demux1to6_reg_if.slave   bus
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [N-1:0]     r_y;
  logic [2:0]       r_dest;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_sel_err;

  logic [5:0]       w_dest_onehot;
  logic             w_fire;
  logic             w_in_ready;
  logic             w_take;
  logic             w_sel_ok;

  // Decode the held destination. Codes 6/7 never get stored, so they map to 0.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    w_dest_onehot = 6'b000000;
    case (r_dest)
      3'd0:    w_dest_onehot = 6'b000001;
      3'd1:    w_dest_onehot = 6'b000010;
      3'd2:    w_dest_onehot = 6'b000100;
      3'd3:    w_dest_onehot = 6'b001000;
      3'd4:    w_dest_onehot = 6'b010000;
      3'd5:    w_dest_onehot = 6'b100000;
      default: w_dest_onehot = 6'b000000;
    endcase
  end

  // Only the selected port's ready bit matters; the others are masked off.
  assign w_fire     = (r_state == S_FULL) && (|(bus.out_ready & w_dest_onehot));
  // Ready depends only on state and out_ready, never on in_valid.
  assign w_in_ready = (r_state == S_EMPTY) || w_fire;
  assign w_take     = bus.in_valid && w_in_ready;
  assign w_sel_ok   = (bus.Sel <= 3'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data register is reset too, since Y must read 0 out of reset.
      r_state    <= S_EMPTY;
      r_y        <= '0;
      r_dest     <= 3'd0;
      r_drop_cnt <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_take && w_sel_ok) begin
        // Covers both a load into EMPTY and a reload on the cycle the old word fires.
        r_state <= S_FULL;
        r_y     <= bus.D;
        r_dest  <= bus.Sel;
      end else if (w_fire) begin
        // Y keeps its last value; consumers qualify it with out_valid.
        r_state <= S_EMPTY;
      end

      if (w_take && !w_sel_ok) begin
        r_sel_err <= 1'b1;
        if (r_drop_cnt != {CNT_W{1'b1}}) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.Y         = r_y;
  assign bus.out_valid = (r_state == S_FULL) ? w_dest_onehot : 6'b000000;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_demux1to6_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1to6_reg
// Two instances: k=0 with CNT_W=8, k=1 with CNT_W=2 (for counter saturation).
// A behavioural model per instance (pending word slot, uncapped drop tally)
// is compared against the DUT outputs on every falling edge; directed phases
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_demux1to6_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per instance.
  logic [31:0] d    [2];
  logic [2:0]  sel  [2];
  logic        iv   [2];
  logic [5:0]  ordy [2];

  // DUT outputs per instance.
  logic [31:0] o_y  [2];
  logic [5:0]  o_ov [2];
  logic [7:0]  o_dc [2];
  logic        o_err[2];
  logic        o_rdy[2];

  demux1to6_reg_if #(.N(32), .CNT_W(8)) bus0 ();
  demux1to6_reg_if #(.N(32), .CNT_W(2)) bus1 ();

  assign bus0.D = d[0];  assign bus0.Sel = sel[0];
  assign bus0.in_valid = iv[0];  assign bus0.out_ready = ordy[0];
  assign bus1.D = d[1];  assign bus1.Sel = sel[1];
  assign bus1.in_valid = iv[1];  assign bus1.out_ready = ordy[1];

  assign o_y[0] = bus0.Y;  assign o_ov[0] = bus0.out_valid;
  assign o_dc[0] = bus0.drop_cnt;  assign o_err[0] = bus0.sel_err;
  assign o_rdy[0] = bus0.in_ready;
  assign o_y[1] = bus1.Y;  assign o_ov[1] = bus1.out_valid;
  assign o_dc[1] = {6'd0, bus1.drop_cnt};  assign o_err[1] = bus1.sel_err;
  assign o_rdy[1] = bus1.in_ready;

  demux1to6_reg #(.N(32), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  demux1to6_reg #(.N(32), .CNT_W(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A slot holding at most one pending word with its port number, and a raw
  // count of dropped words that is clipped to the counter range when compared.
  bit          m_has  [2];
  logic [31:0] m_word [2];
  int          m_port [2];
  int          m_drops[2];
  bit          m_err  [2];
  bit          m_rdy  [2];
  bit          m_take [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      m_rdy[k]  = 1'b1;
      m_take[k] = 1'b0;
      if (m_has[k]) m_rdy[k] = ordy[k][m_port[k]];
      m_take[k] = iv[k] && m_rdy[k];
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_has[k]   <= 1'b0;
        m_word[k]  <= 32'd0;
        m_port[k]  <= 0;
        m_drops[k] <= 0;
        m_err[k]   <= 1'b0;
      end else begin
        if (m_take[k] && int'(sel[k]) < 6) begin
          m_has[k]  <= 1'b1;
          m_word[k] <= d[k];
          m_port[k] <= int'(sel[k]);
        end else if (m_has[k] && ordy[k][m_port[k]]) begin
          m_has[k] <= 1'b0;
        end
        if (m_take[k] && int'(sel[k]) >= 6) begin
          m_drops[k] <= m_drops[k] + 1;
          m_err[k]   <= 1'b1;
        end
      end
    end
  end

  // Compare process: every falling edge, both instances, all outputs.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        int cap;
        cap = (k == 0) ? 255 : 3;
        check($sformatf("k%0d out_valid", k), {26'd0, o_ov[k]},
              m_has[k] ? (32'd1 << m_port[k]) : 32'd0);
        check($sformatf("k%0d Y", k), o_y[k], m_word[k]);
        check($sformatf("k%0d in_ready", k), {31'd0, o_rdy[k]}, {31'd0, m_rdy[k]});
        check($sformatf("k%0d drop_cnt", k), {24'd0, o_dc[k]},
              32'((m_drops[k] > cap) ? cap : m_drops[k]));
        check($sformatf("k%0d sel_err", k), {31'd0, o_err[k]}, {31'd0, m_err[k]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      d[k] = 32'd0; sel[k] = 3'd0; iv[k] = 1'b0; ordy[k] = 6'd0;
    end
    rst = 1'b1;
    started = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst out_valid", {26'd0, o_ov[0]}, 32'd0);
    check("rst Y", o_y[0], 32'd0);
    check("rst drop_cnt", {24'd0, o_dc[0]}, 32'd0);
    check("rst sel_err", {31'd0, o_err[0]}, 32'd0);
    check("rst in_ready", {31'd0, o_rdy[0]}, 32'd1);

    // Single word to port 3.
    d[0] = 32'hDEADBEEF; sel[0] = 3'b011; iv[0] = 1'b1; ordy[0] = 6'b001000;
    step();
    iv[0] = 1'b0;
    check("single out_valid", {26'd0, o_ov[0]}, 32'h08);
    check("single Y", o_y[0], 32'hDEADBEEF);
    step();
    check("single drained", {26'd0, o_ov[0]}, 32'd0);

    // Back-to-back streaming to ports 0..5.
    ordy[0] = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      d[0] = 32'h10 + 32'(i); sel[0] = 3'(i); iv[0] = 1'b1;
      #1 check("stream in_ready", {31'd0, o_rdy[0]}, 32'd1);
      step();
      check("stream out_valid", {26'd0, o_ov[0]}, 32'd1 << i);
      check("stream Y", o_y[0], 32'h10 + 32'(i));
    end
    iv[0] = 1'b0;
    step();

    // Backpressure on port 2 with a second word waiting for port 4.
    ordy[0] = 6'b111011;
    d[0] = 32'hA5A5A5A5; sel[0] = 3'b010; iv[0] = 1'b1;
    step();
    d[0] = 32'h5A5A0001; sel[0] = 3'b100;
    for (int i = 0; i < 4; i++) begin
      check("stall in_ready", {31'd0, o_rdy[0]}, 32'd0);
      check("stall out_valid", {26'd0, o_ov[0]}, 32'h04);
      check("stall Y", o_y[0], 32'hA5A5A5A5);
      step();
    end
    ordy[0] = 6'b111111;
    #1 check("release in_ready", {31'd0, o_rdy[0]}, 32'd1);
    step();
    iv[0] = 1'b0;
    check("second out_valid", {26'd0, o_ov[0]}, 32'h10);
    check("second Y", o_y[0], 32'h5A5A0001);
    step();
    check("second drained", {26'd0, o_ov[0]}, 32'd0);

    // Invalid selects, then a normal word.
    d[0] = 32'h0BAD0006; sel[0] = 3'b110; iv[0] = 1'b1;
    step();
    check("drop6 out_valid", {26'd0, o_ov[0]}, 32'd0);
    d[0] = 32'h0BAD0007; sel[0] = 3'b111;
    step();
    check("drop7 out_valid", {26'd0, o_ov[0]}, 32'd0);
    check("drop drop_cnt", {24'd0, o_dc[0]}, 32'd2);
    check("drop sel_err", {31'd0, o_err[0]}, 32'd1);
    d[0] = 32'h11112222; sel[0] = 3'b001;
    step();
    iv[0] = 1'b0;
    check("after drop out_valid", {26'd0, o_ov[0]}, 32'h02);
    check("after drop Y", o_y[0], 32'h11112222);
    check("after drop sel_err", {31'd0, o_err[0]}, 32'd1);
    step();

    // Saturation on the CNT_W=2 instance.
    ordy[1] = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      d[1] = 32'(i); sel[1] = (i % 2 == 0) ? 3'b110 : 3'b111; iv[1] = 1'b1;
      step();
      check("sat drop_cnt", {24'd0, o_dc[1]}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    iv[1] = 1'b0;
    step();
    step();
    check("sat hold", {24'd0, o_dc[1]}, 32'd3);
    check("sat sel_err", {31'd0, o_err[1]}, 32'd1);

    // Randomised traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        d[k]    = $urandom;
        sel[k]  = 3'($urandom_range(0, 7));
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = 6'($urandom | $urandom);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 6'b111111;
    end
    step();

    // Async reset while a word for port 4 is stalled.
    ordy[0] = 6'b000000;
    d[0] = 32'hCAFE0004; sel[0] = 3'b100; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    check("midrst loaded", {26'd0, o_ov[0]}, 32'h10);
    #2 rst = 1'b1;
    #1;
    check("midrst out_valid", {26'd0, o_ov[0]}, 32'd0);
    check("midrst Y", o_y[0], 32'd0);
    check("midrst drop_cnt", {24'd0, o_dc[0]}, 32'd0);
    check("midrst sel_err", {31'd0, o_err[0]}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    check("postrst in_ready", {31'd0, o_rdy[0]}, 32'd1);
    ordy[0] = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stale never delivered", {26'd0, o_ov[0]}, 32'd0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1to6_reg.md
Name: demux1to6_reg

Overview:
- Registered 1-to-6 demultiplexer with valid/ready handshake; the write-side counterpart of the 6-input datapath select mux.
- Steers one producer word (e.g. ALU/memory result) to one of six consumer ports (register-file banks, vector lanes, forwarding sinks) chosen by a 3-bit select.
- One-entry output holding register gives 1-cycle latency and full throughput, with backpressure per destination.

Parameters:
- N, 32, data width in bits.
- CNT_W, 8, width of the saturating dropped-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- D  input  N  data word from producer.
- Sel  input  3  destination select; 000..101 = port 0..5; 110/111 invalid.
- in_valid  input  1  producer has a word on D/Sel.
- in_ready  output  1  block accepts D/Sel this cycle.
- Y  output  N  held data word, broadcast to all six ports.
- out_valid  output  6  one-hot; bit k = Y valid for port k.
- out_ready  input  6  bit k = port k consumes this cycle.
- drop_cnt  output  CNT_W  count of words dropped for invalid Sel, saturating.
- sel_err  output  1  sticky flag: an invalid Sel was accepted.

Behaviour:
- Reset (async, rst=1): full=0, out_valid=0, Y=0, drop_cnt=0, sel_err=0. in_ready=1 as soon as rst deasserts. Any held word is discarded; a handshake in progress is lost.
- State is one holding register (full, Y, dest[2:0]). There are two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid = onehot(dest).
- Output fire: FULL && out_ready[dest]. Bits of out_ready for non-selected ports are ignored.
- in_ready = !full || fire. It is combinational from out_ready and has no dependence on in_valid.
- Accept: in_valid && in_ready, with Sel <= 101.
  - Next cycle: full=1, Y=D, dest=Sel.
  - Latency is D at input to out_valid at output = 1 cycle.
- Drop: in_valid && in_ready with Sel in {110,111}.
  - The word is consumed: it counts as a handshake and is never presented.
  - drop_cnt increments unless it equals 2^CNT_W-1; at that value it holds.
  - sel_err is set to 1 and stays set until reset.
  - full becomes 0 next cycle, unless a new accept occurs in that same cycle; it cannot, since only one input word is taken per cycle.
- Simultaneous fire and accept: the register reloads with the new word; out_valid stays asserted, possibly moving to a different bit. Sustained throughput is 1 word/cycle when the consumer stays ready.
- Simultaneous fire and drop: full=0 next cycle.
- Stall rules (FULL and !out_ready[dest]):
  - Y, dest and out_valid are held stable.
  - in_ready=0, so D/Sel are not sampled.
- out_valid is always one-hot or zero. It never has more than one bit set.
- Y is not cleared after fire; it holds the last word. Consumers must qualify Y with out_valid.
- A producer may deassert in_valid at any time when not handshaking. No combinational path exists from in_valid to any output.

Test Plan:
- Reset then single word: D=0xDEADBEEF, Sel=011, in_valid=1 for 1 cycle, out_ready=6'b001000 -> next cycle out_valid=6'b001000, Y=0xDEADBEEF; the cycle after, out_valid=0.
- Back-to-back streaming: 6 words 0x10..0x15 to Sel=0..5 on consecutive cycles, out_ready=6'b111111 -> out_valid walks 000001..100000 on consecutive cycles, Y matches each word, and in_ready stays 1 throughout.
- Backpressure: word 0xA5A5A5A5 to Sel=010 with out_ready[2]=0 for 4 cycles and all other ready bits 1.
  - Y and out_valid=6'b000100 stay stable for 4 cycles with in_ready=0.
  - A second word offered during the stall is not taken.
  - After out_ready[2]=1, the second word appears the next cycle.
- Invalid select: Sel=110 then Sel=111, each with in_valid=1 -> no out_valid pulse, drop_cnt=2, sel_err=1. A following valid word to Sel=001 is delivered normally, and sel_err stays 1.
- Counter saturation with CNT_W=2: 5 invalid-Sel words -> drop_cnt reads 3 and stays 3.
- Reset mid-operation: FULL with a stalled word to port 4, assert rst asynchronously between clock edges.
  - out_valid=0, Y=0, drop_cnt=0 and sel_err=0 immediately.
  - After release, in_ready=1 and the stale word is never delivered.
